// File: rtl/wide_add_sequencer_if.sv
// Request/result bundle between a controller and wide_add_sequencer; operands are 32*WORDS bits.
// master drives the request and operands, slave returns busy/done and the held result.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int W = 32 * WORDS;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide add/sub by sequencing one 32-bit carry-select adder over WORDS limbs, LSB first.
// done pulses WORDS+1 cycles after accept; start is only sampled in IDLE, ignored while busy.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [31:0]   limb_a, limb_b, limb_s;
    logic          limb_co;
    logic          last_limb;

    assign limb_a    = a_q[32*idx_q +: 32];
    assign limb_b    = b_q[32*idx_q +: 32];
    assign last_limb = (idx_q == IW'(WORDS - 1));

    CarrySelectAdder u_adder (
        .a  (limb_a),
        .b  (limb_b),
        .ci (carry_q),
        .s  (limb_s),
        .co (limb_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_limb) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1, so B is inverted and the carry seeded once at accept.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                acc_d[32*idx_q +: 32] = limb_s;
                carry_d               = limb_co;
                if (last_limb) begin
                    sum_d  = acc_d;
                    cout_d = limb_co;
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.sum      = sum_q;
        bus.cout     = cout_q;
        bus.overflow = ovf_q;
    end
endmodule

// Upper half is computed for both carry values and picked by the lower-half carry.
module CarrySelectAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    assign lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'b0, ci};
    assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign s  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
    assign co = lo[16] ? hi1[16] : hi0[16];
endmodule
